tile_turn_controller: RTL
=========================

# tile_turn_controller

Per-turn sequencer for the tile-matching game: decodes PS2 scan codes into cursor moves and tile picks, fetches tile values from the board memory, times the reveal window, and maintains the revealed/matched masks and the move counter. It sits under the game-mode controller, enabled by `ingameOn`, and returns `gameOver` to it once every pair is matched.

## Interface
- `ROWS`, 4, board rows
- `COLS`, 4, board columns; `N = ROWS*COLS` must be even, `IW = $clog2(N)`
- `VAL_W`, 3, tile value width
- `REVEAL_CYCLES`, 50_000_000, reveal-window length in clk cycles (1 s at 50 MHz), ≥ 1
- `MOVES_W`, 8, move counter width
- `clk` in 1 system clock, rising edge
- `resetn` in 1 asynchronous active-low reset
- `ingameOn` in 1 level, enables play; low forces IDLE
- `ps2_key_data` in 8 scan-code byte, valid when `ps2_key_pressed`=1
- `ps2_key_pressed` in 1 one-cycle strobe per received byte
- `tile_addr` out IW board memory read address
- `tile_value` in VAL_W read data, valid the cycle after `tile_addr` is presented (synchronous ROM)
- `cursor` out IW selected tile index (`row*COLS+col`)
- `revealed` out N face-up, unmatched tiles
- `matched` out N matched tiles
- `moves` out MOVES_W completed turns, saturating
- `gameOver` out 1 high in DONE
- `turnState` out 3 state code, for hex debug

## Operation
- States (code): IDLE 0, PICK1 1, FETCH1 2, PICK2 3, FETCH2 4, SHOW 5, RESOLVE 6, DONE 7.
- Key decode, every state: byte F0 sets `brk`; the next byte clears `brk` and is dropped. Byte E0 dropped, no flag. Any other byte with `brk`=0 is a make code.
- Make codes: W 1D row-1, S 1B row+1, A 1C col-1, D 23 col+1, Enter 5A pick; others ignored. Row/col wrap modulo ROWS/COLS independently.
- Moves/picks act only in PICK1/PICK2; make codes are dropped in all other states.
- IDLE: cursor, masks, `moves`, pair count, `brk` cleared. `ingameOn`=1 → PICK1.
- PICK1: Enter on tile with `revealed|matched` bit clear → set `revealed[cursor]`, `first=cursor`, `tile_addr=cursor`, → FETCH1. Enter on an ineligible tile ignored.
- FETCH1: latch `v1=tile_value` → PICK2.
- PICK2: same as PICK1 but `second=cursor`, → FETCH2.
- FETCH2: latch `v2`; `moves` += 1 unless all-ones; load timer REVEAL_CYCLES-1 → SHOW.
- SHOW: timer decrements each cycle; at 0 → RESOLVE.
- RESOLVE (one cycle): clear `revealed[first]`, `revealed[second]`; if `v1==v2` set both `matched` bits, pairs += 1. If pairs becomes N/2 → DONE else PICK1.
- DONE: `gameOver`=1; held until `ingameOn`=0.
- `ingameOn`=0 in any state → IDLE next edge (clears as above; mid-SHOW turn discarded).
- `tile_addr` holds last driven value outside pick cycles.

## Timing
- All outputs reset to 0 asynchronously; state IDLE, `brk`=0.
- Make code in strobe cycle k updates `cursor`/`revealed` visible at k+1.
- Pick to SHOW: Enter at k → FETCH1 at k+1 (first pick); second Enter at m → FETCH2 m+1 → SHOW m+2.
- SHOW lasts exactly REVEAL_CYCLES cycles; RESOLVE one cycle; masks updated on leaving RESOLVE.
- `gameOver` asserts the cycle after the final RESOLVE.
- Byte strobe coincident with a state transition is evaluated against the current state.
- `moves` saturates at 2^MOVES_W−1, no wrap.

## Configuration
- `TURN_MATCH_FASTPATH_EN` defined: in FETCH2, if `v1==v2`, go directly to RESOLVE (skip SHOW, no timer load); mismatches still take SHOW.
- Undefined: every turn passes through SHOW for REVEAL_CYCLES cycles.

## Test plan
- Reset then `ingameOn`=1 → state PICK1 next cycle, cursor 0, masks 0, `moves` 0.
- Bytes 1C at cursor 0; then 1D → cursor 3 then 15 (wrap left and up, 4x4).
- Bytes F0,5A with cursor 0 → no pick (break dropped); bytes 5A → `revealed`=0x0001, `tile_addr`=0.
- Picks tiles 0,1 holding values 2,5 (REVEAL_CYCLES=4) → SHOW 4 cycles, then `revealed`=0, `matched`=0, `moves`=1; Enter during SHOW ignored.
- Pair up all 8 values → `matched`=0xFFFF, `gameOver`=1; drop `ingameOn` → IDLE, all outputs 0.
- `resetn` low mid-SHOW → all outputs 0 immediately; with `TURN_MATCH_FASTPATH_EN`, equal pair resolves 2 cycles after second Enter.

Source files
------------

// File: rtl/tile_turn_controller.sv
// tile_turn_controller: per-turn sequencer for the tile-matching game.
// Decodes PS2 scan codes into cursor moves and picks, fetches tile values,
// times the reveal window and keeps the revealed/matched masks and move count.
// Optional feature macro: TURN_MATCH_FASTPATH_EN (equal pairs skip SHOW).
module tile_turn_controller #(
  parameter int ROWS          = 4,
  parameter int COLS          = 4,
  parameter int VAL_W         = 3,
  parameter int REVEAL_CYCLES = 50_000_000,
  parameter int MOVES_W       = 8,
  localparam int N            = ROWS * COLS,
  localparam int IW           = $clog2(N)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               ingameOn,
  input  logic [7:0]         ps2_key_data,
  input  logic               ps2_key_pressed,
  output logic [IW-1:0]      tile_addr,
  input  logic [VAL_W-1:0]   tile_value,
  output logic [IW-1:0]      cursor,
  output logic [N-1:0]       revealed,
  output logic [N-1:0]       matched,
  output logic [MOVES_W-1:0] moves,
  output logic               gameOver,
  output logic [2:0]         turnState
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int TW = (REVEAL_CYCLES > 1) ? $clog2(REVEAL_CYCLES) : 1;
  localparam int PW = $clog2(N / 2 + 1);

  localparam logic [7:0] KEY_BREAK = 8'hF0;
  localparam logic [7:0] KEY_EXT   = 8'hE0;
  localparam logic [7:0] KEY_UP    = 8'h1D;
  localparam logic [7:0] KEY_DOWN  = 8'h1B;
  localparam logic [7:0] KEY_LEFT  = 8'h1C;
  localparam logic [7:0] KEY_RIGHT = 8'h23;
  localparam logic [7:0] KEY_ENTER = 8'h5A;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PICK1   = 3'd1,
    S_FETCH1  = 3'd2,
    S_PICK2   = 3'd3,
    S_FETCH2  = 3'd4,
    S_SHOW    = 3'd5,
    S_RESOLVE = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  state_t             state_q, state_d;
  logic [RW-1:0]      row_q, row_d;
  logic [CW-1:0]      col_q, col_d;
  logic               brk_q, brk_d;
  logic [N-1:0]       revealed_q, revealed_d;
  logic [N-1:0]       matched_q, matched_d;
  logic [MOVES_W-1:0] moves_q, moves_d;
  logic [PW-1:0]      pairs_q, pairs_d;
  logic [IW-1:0]      first_q, first_d;
  logic [IW-1:0]      second_q, second_d;
  logic [VAL_W-1:0]   v1_q, v1_d;
  logic [VAL_W-1:0]   v2_q, v2_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [IW-1:0]      tile_addr_q, tile_addr_d;

  logic               key_make;
  logic               pick;
  logic               eligible;
  logic [IW-1:0]      cur_idx;

  assign cur_idx  = IW'(row_q) * IW'(COLS) + IW'(col_q);
  assign eligible = ~(revealed_q[cur_idx] | matched_q[cur_idx]);

  // Key decode, turn sequencing and mask/counter updates for the next cycle
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    brk_d       = brk_q;
    revealed_d  = revealed_q;
    matched_d   = matched_q;
    moves_d     = moves_q;
    pairs_d     = pairs_q;
    first_d     = first_q;
    second_d    = second_q;
    v1_d        = v1_q;
    v2_d        = v2_q;
    timer_d     = timer_q;
    tile_addr   = tile_addr_q;
    tile_addr_d = tile_addr_q;
    key_make    = 1'b0;
    pick        = 1'b0;

    if (ps2_key_pressed) begin
      if (ps2_key_data == KEY_BREAK) begin
        brk_d = 1'b1;
      end else if (brk_q) begin
        brk_d = 1'b0;
      end else if (ps2_key_data != KEY_EXT) begin
        key_make = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        state_d = S_PICK1;
      end
      S_PICK1, S_PICK2: begin
        if (key_make) begin
          case (ps2_key_data)
            KEY_UP:    row_d = (row_q == '0) ? RW'(ROWS - 1) : row_q - RW'(1);
            KEY_DOWN:  row_d = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
            KEY_LEFT:  col_d = (col_q == '0) ? CW'(COLS - 1) : col_q - CW'(1);
            KEY_RIGHT: col_d = (col_q == CW'(COLS - 1)) ? '0 : col_q + CW'(1);
            KEY_ENTER: begin
              if (eligible) begin
                pick                = 1'b1;
                revealed_d[cur_idx] = 1'b1;
                if (state_q == S_PICK1) begin
                  first_d = cur_idx;
                  state_d = S_FETCH1;
                end else begin
                  second_d = cur_idx;
                  state_d  = S_FETCH2;
                end
              end
            end
            default: ;
          endcase
        end
      end
      S_FETCH1: begin
        v1_d    = tile_value;
        state_d = S_PICK2;
      end
      S_FETCH2: begin
        v2_d = tile_value;
        if (moves_q != '1) begin
          moves_d = moves_q + MOVES_W'(1);
        end
`ifdef TURN_MATCH_FASTPATH_EN
        if (v1_q == tile_value) begin
          state_d = S_RESOLVE;
        end else begin
          timer_d = TW'(REVEAL_CYCLES - 1);
          state_d = S_SHOW;
        end
`else
        timer_d = TW'(REVEAL_CYCLES - 1);
        state_d = S_SHOW;
`endif
      end
      S_SHOW: begin
        if (timer_q == '0) begin
          state_d = S_RESOLVE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_RESOLVE: begin
        revealed_d[first_q]  = 1'b0;
        revealed_d[second_q] = 1'b0;
        if (v1_q == v2_q) begin
          matched_d[first_q]  = 1'b1;
          matched_d[second_q] = 1'b1;
          pairs_d             = pairs_q + PW'(1);
        end
        state_d = (pairs_d == PW'(N / 2)) ? S_DONE : S_PICK1;
      end
      S_DONE: ;
      default: state_d = S_IDLE;
    endcase

    if (state_q == S_IDLE || !ingameOn) begin
      pick       = 1'b0;
      row_d      = '0;
      col_d      = '0;
      brk_d      = 1'b0;
      revealed_d = '0;
      matched_d  = '0;
      moves_d    = '0;
      pairs_d    = '0;
      if (!ingameOn) begin
        state_d = S_IDLE;
      end
    end

    if (pick) begin
      tile_addr = cur_idx;
    end
    tile_addr_d = (state_q == S_IDLE || !ingameOn) ? '0 : tile_addr;
  end

  // State and datapath registers, cleared asynchronously on reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      brk_q       <= 1'b0;
      revealed_q  <= '0;
      matched_q   <= '0;
      moves_q     <= '0;
      pairs_q     <= '0;
      first_q     <= '0;
      second_q    <= '0;
      v1_q        <= '0;
      v2_q        <= '0;
      timer_q     <= '0;
      tile_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      brk_q       <= brk_d;
      revealed_q  <= revealed_d;
      matched_q   <= matched_d;
      moves_q     <= moves_d;
      pairs_q     <= pairs_d;
      first_q     <= first_d;
      second_q    <= second_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      timer_q     <= timer_d;
      tile_addr_q <= tile_addr_d;
    end
  end

  assign cursor    = cur_idx;
  assign revealed  = revealed_q;
  assign matched   = matched_q;
  assign moves     = moves_q;
  assign gameOver  = (state_q == S_DONE);
  assign turnState = state_q;

endmodule
